// File: rtl/rts_bist_if.sv
// Handshake/status bundle between the test access logic and the RTS scan-BIST controller.
// slave = controller side, master = test access / datapath side.
interface rts_bist_if #(
  parameter int SIG_W = 16,
  parameter int RC_W  = 6
);
  logic             start;
  logic             abort;
  logic [SIG_W-1:0] sig_in;
  logic             NbarT;
  logic             rstOut;
  logic             PRPG_En;
  logic             SRSG_En;
  logic             SISA_En;
  logic             MISR_En;
  logic             busy;
  logic             done;
  logic             pass;
  logic [RC_W-1:0]  round_cnt;

  modport slave (
    input  start, abort, sig_in,
    output NbarT, rstOut, PRPG_En, SRSG_En, SISA_En, MISR_En, busy, done, pass, round_cnt
  );

  modport master (
    output start, abort, sig_in,
    input  NbarT, rstOut, PRPG_En, SRSG_En, SISA_En, MISR_En, busy, done, pass, round_cnt
  );
endinterface

// File: rtl/rts_bist_controller.sv
// Sequencer for the RTS scan-BIST loop: PRPG generate, scan shift, capture, MISR sign,
// optional SISA flush and final golden-signature compare, restartable and abortable.
module rts_bist_controller #(
  parameter int             SHIFT_SIZE     = 8,
  parameter int             NUM_ROUNDS     = 50,
  parameter int             CAPTURE_CYCLES = 1,
  parameter bit             FLUSH_EN       = 1'b1,
  parameter int             SIG_W          = 16,
  parameter logic [SIG_W-1:0] GOLDEN_SIG   = '0
) (
  input logic       clk,
  input logic       rstIn,
  rts_bist_if.slave bus
);
  localparam int RC_W = ($clog2(NUM_ROUNDS + 1) < 1) ? 1 : $clog2(NUM_ROUNDS + 1);
  localparam int SC_W = ($clog2(SHIFT_SIZE + 1) < 1) ? 1 : $clog2(SHIFT_SIZE + 1);
  localparam int CC_W = ($clog2(CAPTURE_CYCLES + 1) < 1) ? 1 : $clog2(CAPTURE_CYCLES + 1);

  localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(SHIFT_SIZE - 1);
  localparam logic [CC_W-1:0] CAP_LAST   = CC_W'(CAPTURE_CYCLES - 1);
  localparam logic [RC_W-1:0] ROUND_LAST = RC_W'(NUM_ROUNDS - 1);
  localparam logic [RC_W-1:0] ROUND_MAX  = RC_W'(NUM_ROUNDS);

  typedef enum logic [3:0] {
    IDLE, INIT, GEN, SHIFT, CAPTURE, SIGN, FLUSH, COMPARE, DONE
  } state_t;

  typedef struct packed {
    logic nbarT;
    logic rstOut;
    logic prpgEn;
    logic srsgEn;
    logic sisaEn;
    logic misrEn;
    logic busy;
    logic done;
  } ctrl_t;

  state_t          state;
  state_t          nextState;
  ctrl_t           ctrlQ;
  logic [SC_W-1:0] shiftCnt;
  logic [CC_W-1:0] capCnt;
  logic [RC_W-1:0] roundCnt;
  logic            passQ;

  function automatic logic isBusy(state_t s);
    return (s == INIT) || (s == GEN) || (s == SHIFT) || (s == CAPTURE) ||
           (s == SIGN) || (s == FLUSH) || (s == COMPARE);
  endfunction

  function automatic state_t stepState(state_t s, logic st, logic ab,
                                       logic [SC_W-1:0] sc, logic [CC_W-1:0] cc,
                                       logic [RC_W-1:0] rc);
    state_t n;
    n = IDLE;
    case (s)
      IDLE:    n = st ? INIT : IDLE;
      DONE:    n = st ? INIT : DONE;
      INIT:    n = GEN;
      GEN:     n = SHIFT;
      SHIFT:   n = (sc == SHIFT_LAST) ? CAPTURE : SHIFT;
      CAPTURE: n = (cc == CAP_LAST) ? SIGN : CAPTURE;
      SIGN:    n = (rc == ROUND_LAST) ? (FLUSH_EN ? FLUSH : COMPARE) : GEN;
      FLUSH:   n = (sc == SHIFT_LAST) ? COMPARE : FLUSH;
      COMPARE: n = DONE;
      default: n = IDLE;
    endcase
    // Abort only acts while a run is in flight; in IDLE/DONE start wins.
    if (ab && isBusy(s)) n = IDLE;
    return n;
  endfunction

  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      INIT:    begin c.nbarT = 1'b1; c.rstOut = 1'b1; end
      GEN:     c.prpgEn = 1'b1;
      SHIFT:   begin c.nbarT = 1'b1; c.srsgEn = 1'b1; c.sisaEn = 1'b1; end
      SIGN:    c.misrEn = 1'b1;
      FLUSH:   begin c.nbarT = 1'b1; c.sisaEn = 1'b1; end
      default: c = '0;
    endcase
    c.busy = isBusy(s);
    c.done = (s == DONE);
    return c;
  endfunction

  assign nextState = stepState(state, bus.start, bus.abort, shiftCnt, capCnt, roundCnt);

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rstIn) begin
      state    <= IDLE;
      ctrlQ    <= '0;
      shiftCnt <= '0;
      capCnt   <= '0;
      roundCnt <= '0;
      passQ    <= 1'b0;
    end else begin
      state <= nextState;
      ctrlQ <= decode(nextState);
      if (bus.abort && isBusy(state)) begin
        passQ <= 1'b0;
      end else begin
        case (state)
          INIT: begin
            roundCnt <= '0;
            passQ    <= 1'b0;
          end
          GEN: begin
            shiftCnt <= '0;
            capCnt   <= '0;
          end
          SHIFT:   shiftCnt <= shiftCnt + SC_W'(1);
          CAPTURE: capCnt <= capCnt + CC_W'(1);
          SIGN: begin
            if (roundCnt != ROUND_MAX) roundCnt <= roundCnt + RC_W'(1);
            shiftCnt <= '0;
          end
          FLUSH:   shiftCnt <= shiftCnt + SC_W'(1);
          COMPARE: passQ <= (bus.sig_in == GOLDEN_SIG);
          default: ;
        endcase
      end
    end
  end

  assign bus.NbarT     = ctrlQ.nbarT;
  assign bus.rstOut    = ctrlQ.rstOut;
  assign bus.PRPG_En   = ctrlQ.prpgEn;
  assign bus.SRSG_En   = ctrlQ.srsgEn;
  assign bus.SISA_En   = ctrlQ.sisaEn;
  assign bus.MISR_En   = ctrlQ.misrEn;
  assign bus.busy      = ctrlQ.busy;
  assign bus.done      = ctrlQ.done;
  assign bus.pass      = passQ;
  assign bus.round_cnt = roundCnt;
endmodule

// File: tb/tb_rts_bist_controller.sv
// Bench for rts_bist_controller: a table-driven run on a short no-flush configuration and
// directed plus random runs on a flushing configuration checked against a schedule model.
module tb_rts_bist_controller;
  localparam int          A_S = 4, A_R = 3, A_C = 1;
  localparam bit          A_F = 1'b1;
  localparam logic [15:0] A_G = 16'hBEEF;
  localparam logic [15:0] B_G = 16'h1234;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic rstA, rstB;
  rts_bist_if #(.SIG_W(16), .RC_W(2)) busA();
  rts_bist_if #(.SIG_W(16), .RC_W(1)) busB();

  rts_bist_controller #(.SHIFT_SIZE(A_S), .NUM_ROUNDS(A_R), .CAPTURE_CYCLES(A_C),
    .FLUSH_EN(A_F), .SIG_W(16), .GOLDEN_SIG(A_G)) dutA (.clk(clk), .rstIn(rstA), .bus(busA));
  rts_bist_controller #(.SHIFT_SIZE(1), .NUM_ROUNDS(1), .CAPTURE_CYCLES(3),
    .FLUSH_EN(1'b0), .SIG_W(16), .GOLDEN_SIG(B_G)) dutB (.clk(clk), .rstIn(rstB), .bus(busB));

  // {NbarT, rstOut, PRPG_En, SRSG_En, SISA_En, MISR_En, busy, done}
  wire [7:0] vecA = {busA.NbarT, busA.rstOut, busA.PRPG_En, busA.SRSG_En,
                     busA.SISA_En, busA.MISR_En, busA.busy, busA.done};
  wire [7:0] vecB = {busB.NbarT, busB.rstOut, busB.PRPG_En, busB.SRSG_En,
                     busB.SISA_En, busB.MISR_En, busB.busy, busB.done};

  // Reference model: a run is an expanded list of phases, consumed one per clock.
  typedef enum int {P_INIT, P_GEN, P_SHIFT, P_CAP, P_SIGN, P_FLUSH, P_CMP} phase_e;
  phase_e plan[$];
  phase_e cur;
  int     mMode = 0;  // 0 idle, 1 running, 2 done
  int     mRc = 0;
  bit     mPass = 1'b0;
  bit     mValid = 1'b0;

  function automatic logic [7:0] phaseOuts(phase_e p);
    case (p)
      P_INIT:  return 8'hC2;
      P_GEN:   return 8'h22;
      P_SHIFT: return 8'h9A;
      P_CAP:   return 8'h02;
      P_SIGN:  return 8'h06;
      P_FLUSH: return 8'h8A;
      default: return 8'h02;
    endcase
  endfunction

  task automatic buildPlan();
    plan.delete();
    plan.push_back(P_INIT);
    for (int r = 0; r < A_R; r++) begin
      plan.push_back(P_GEN);
      for (int i = 0; i < A_S; i++) plan.push_back(P_SHIFT);
      for (int i = 0; i < A_C; i++) plan.push_back(P_CAP);
      plan.push_back(P_SIGN);
    end
    if (A_F) for (int i = 0; i < A_S; i++) plan.push_back(P_FLUSH);
    plan.push_back(P_CMP);
  endtask

  always @(posedge clk) begin
    logic rs, st, ab;
    logic [15:0] sg;
    logic [7:0] expV;
    rs = rstA; st = busA.start; ab = busA.abort; sg = busA.sig_in;
    if (rs) begin
      mMode = 0; mRc = 0; mPass = 1'b0; mValid = 1'b1;
    end else if (mValid) begin
      if (mMode != 1) begin
        if (st) begin
          buildPlan();
          cur = plan.pop_front();
          mMode = 1;
        end
      end else if (ab) begin
        mMode = 0; mPass = 1'b0;
      end else begin
        case (cur)
          P_INIT: begin mRc = 0; mPass = 1'b0; end
          P_SIGN: if (mRc < A_R) mRc++;
          P_CMP:  mPass = (sg == A_G);
          default: ;
        endcase
        if (plan.size() == 0) mMode = 2;
        else cur = plan.pop_front();
      end
    end
    #2;
    if (mValid) begin
      expV = (mMode == 0) ? 8'h00 : (mMode == 2) ? 8'h01 : phaseOuts(cur);
      chk("A.outputs", vecA, expV);
      chk("A.round_cnt", busA.round_cnt, mRc);
      chk("A.pass", busA.pass, mPass);
    end
  end

  typedef struct {
    bit          rst, start, abort;
    logic [15:0] sig;
    logic [7:0]  outs;
    int          rc;
    bit          pass;
  } vecB_t;

  function automatic vecB_t mk(bit r, bit s, bit a, logic [15:0] g, logic [7:0] o, int rc, bit p);
    vecB_t v;
    v.rst = r; v.start = s; v.abort = a; v.sig = g; v.outs = o; v.rc = rc; v.pass = p;
    return v;
  endfunction

  task automatic runA(output int cyc, output int srsg);
    busA.start = 1'b1;
    @(negedge clk);
    busA.start = 1'b0;
    chk("A.rstOut_in_INIT", busA.rstOut, 1);
    cyc = 0; srsg = 0;
    while (!busA.done && cyc < 200) begin
      if (busA.SRSG_En) srsg++;
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("A.rstOut_after_INIT", busA.rstOut, 0);
        chk("A.round_cnt_cleared", busA.round_cnt, 0);
      end
    end
  endtask

  vecB_t tbl[25];
  int cyc, srsg, firstCyc;

  initial begin
    rstA = 1'b1; rstB = 1'b1;
    busA.start = 1'b0; busA.abort = 1'b0; busA.sig_in = A_G;
    busB.start = 1'b0; busB.abort = 1'b0; busB.sig_in = B_G;

    tbl[0]  = mk(1, 0, 0, B_G,   8'h00, 0, 0);
    tbl[1]  = mk(0, 0, 0, B_G,   8'h00, 0, 0);
    tbl[2]  = mk(0, 1, 0, B_G,   8'hC2, 0, 0);
    tbl[3]  = mk(0, 0, 0, B_G,   8'h22, 0, 0);
    tbl[4]  = mk(0, 0, 0, B_G,   8'h9A, 0, 0);
    tbl[5]  = mk(0, 0, 0, B_G,   8'h02, 0, 0);
    tbl[6]  = mk(0, 0, 0, B_G,   8'h02, 0, 0);
    tbl[7]  = mk(0, 0, 0, B_G,   8'h02, 0, 0);
    tbl[8]  = mk(0, 0, 0, B_G,   8'h06, 0, 0);
    tbl[9]  = mk(0, 0, 0, B_G,   8'h02, 1, 0);
    tbl[10] = mk(0, 0, 0, B_G,   8'h01, 1, 1);
    tbl[11] = mk(0, 1, 1, B_G,   8'hC2, 1, 1);
    tbl[12] = mk(0, 0, 0, B_G,   8'h22, 0, 0);
    tbl[13] = mk(0, 0, 1, B_G,   8'h00, 0, 0);
    tbl[14] = mk(0, 1, 0, 16'h0, 8'hC2, 0, 0);
    tbl[15] = mk(0, 0, 0, 16'h0, 8'h22, 0, 0);
    tbl[16] = mk(0, 1, 0, 16'h0, 8'h9A, 0, 0);
    tbl[17] = mk(0, 0, 0, 16'h0, 8'h02, 0, 0);
    tbl[18] = mk(0, 0, 0, 16'h0, 8'h02, 0, 0);
    tbl[19] = mk(0, 0, 0, 16'h0, 8'h02, 0, 0);
    tbl[20] = mk(0, 0, 0, 16'h0, 8'h06, 0, 0);
    tbl[21] = mk(0, 0, 0, 16'h0, 8'h02, 1, 0);
    tbl[22] = mk(0, 0, 0, 16'h0, 8'h01, 1, 0);
    tbl[23] = mk(1, 0, 0, 16'h0, 8'h00, 0, 0);
    tbl[24] = mk(0, 0, 1, 16'h0, 8'h00, 0, 0);

    @(negedge clk);
    @(negedge clk);
    rstA = 1'b0;

    for (int i = 0; i < 25; i++) begin
      rstB = tbl[i].rst; busB.start = tbl[i].start;
      busB.abort = tbl[i].abort; busB.sig_in = tbl[i].sig;
      @(posedge clk);
      #2;
      chk($sformatf("B.row%0d.outputs", i), vecB, tbl[i].outs);
      chk($sformatf("B.row%0d.round_cnt", i), busB.round_cnt, tbl[i].rc);
      chk($sformatf("B.row%0d.pass", i), busB.pass, tbl[i].pass);
      @(negedge clk);
    end
    busB.start = 1'b0; busB.abort = 1'b0;

    // Golden signature match, then a near-miss from DONE.
    busA.sig_in = A_G;
    runA(cyc, srsg);
    chk("A.run1_cycles", cyc, 27);
    chk("A.run1_srsg_cycles", srsg, A_R * A_S);
    chk("A.run1_pass", busA.pass, 1);
    chk("A.run1_round_cnt", busA.round_cnt, 3);
    firstCyc = cyc;
    busA.sig_in = 16'hBEEE;
    runA(cyc, srsg);
    chk("A.rerun_cycles", cyc, firstCyc);
    chk("A.run2_pass", busA.pass, 0);
    chk("A.run2_done", busA.done, 1);

    // Abort in the second round's SHIFT.
    busA.sig_in = A_G;
    busA.start = 1'b1;
    @(negedge clk);
    busA.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("A.abort_pre_shift", vecA, 8'h9A);
    busA.abort = 1'b1;
    @(negedge clk);
    busA.abort = 1'b0;
    chk("A.abort_busy", busA.busy, 0);
    chk("A.abort_pass", busA.pass, 0);
    chk("A.abort_outputs", vecA, 8'h00);
    chk("A.abort_round_cnt_held", busA.round_cnt, 1);
    runA(cyc, srsg);
    chk("A.after_abort_cycles", cyc, 27);
    chk("A.after_abort_pass", busA.pass, 1);

    // Reset in the second round's CAPTURE.
    busA.start = 1'b1;
    @(negedge clk);
    busA.start = 1'b0;
    repeat (13) @(negedge clk);
    chk("A.rst_pre_capture", vecA, 8'h02);
    rstA = 1'b1;
    @(negedge clk);
    rstA = 1'b0;
    chk("A.rst_outputs", vecA, 8'h00);
    chk("A.rst_round_cnt", busA.round_cnt, 0);
    chk("A.rst_pass", busA.pass, 0);
    repeat (3) @(negedge clk);
    chk("A.rst_stays_idle", vecA, 8'h00);
    runA(cyc, srsg);
    chk("A.after_rst_cycles", cyc, 27);

    // Random start/abort/reset traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      busA.start  = ($urandom_range(0, 7) == 0);
      busA.abort  = ($urandom_range(0, 39) == 0);
      rstA        = ($urandom_range(0, 199) == 0);
      busA.sig_in = ($urandom_range(0, 1) == 0) ? A_G : 16'($urandom);
      @(negedge clk);
    end
    busA.start = 1'b0; busA.abort = 1'b0; rstA = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
